determinante_nxn_seq: RTL and testbench

- Sequential, parametrised N×N integer determinant unit; the multi-cycle successor to the team's combinational fixed-size determinant blocks.
- Uses fraction-free (Bareiss) elimination with row swapping, so the result is exact for all signed inputs.
- Accepts one flattened matrix per start/done transaction.
- Sits beside the other matrix operation units and is driven by the operation controller.

---
 rtl/determinante_nxn_seq.sv | 204 ++++++++++++++++++++
 tb/tb_determinante_nxn_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/determinante_nxn_seq.sv
// Sequential N x N signed integer determinant using fraction-free (Bareiss)
// elimination with row swapping; one flattened matrix per start/done transaction.
module determinante_nxn_seq #(
  parameter int N     = 5,
  parameter int W     = 8,
  parameter int DET_W = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N*N*W-1:0]        matriz,
  output logic                    busy,
  output logic                    done,
  output logic signed [DET_W-1:0] det
);

  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIVOT,
    S_SWAP,
    S_ELIM,
    S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic signed [DET_W-1:0] a_q [N][N];
  logic signed [DET_W-1:0] a_d [N][N];
  logic signed [DET_W-1:0] prev_q, prev_d;
  logic signed [DET_W-1:0] det_q, det_d;
  logic                    sign_q, sign_d;
  logic                    zero_q, zero_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [IW-1:0]           k_q, k_d;
  logic [IW-1:0]           i_q, i_d;
  logic [IW-1:0]           j_q, j_d;
  logic [IW-1:0]           p_q, p_d;

  function automatic logic signed [2*DET_W-1:0] sext(input logic signed [DET_W-1:0] v);
    return {{DET_W{v[DET_W-1]}}, v};
  endfunction

  // One Bareiss update per cycle; the quotient is exact, so truncation loses nothing.
  logic signed [2*DET_W-1:0] num_w;
  logic signed [2*DET_W-1:0] div_w;
  logic signed [DET_W-1:0]   elim_val;
  logic                      elim_en;

  assign num_w    = sext(a_q[i_q][j_q]) * sext(a_q[k_q][k_q])
                  - sext(a_q[i_q][k_q]) * sext(a_q[k_q][j_q]);
  assign div_w    = sext(prev_q);
  assign elim_val = DET_W'(num_w / div_w);
  assign elim_en  = (state_q == S_ELIM);

  // Lowest row below k with a nonzero entry in column k.
  logic          piv_found;
  logic [IW-1:0] piv_row;

  always_comb begin
    piv_found = 1'b0;
    piv_row   = '0;
    for (int r = N - 1; r >= 0; r--) begin
      if (r > int'(k_q) && a_q[r][k_q] != '0) begin
        piv_found = 1'b1;
        piv_row   = IW'(r);
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    prev_d  = prev_q;
    det_d   = det_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = done_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    p_d     = p_q;

    if (elim_en) a_d[i_q][j_q] = elim_val;

    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              a_d[r][c] = DET_W'($signed(matriz[(r*N+c)*W +: W]));
            end
          end
          prev_d  = DET_W'(1);
          sign_d  = 1'b0;
          zero_d  = 1'b0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = S_PIVOT;
        end
      end

      S_PIVOT: begin
        if (a_q[k_q][k_q] != '0) begin
          i_d     = k_q + IW'(1);
          j_d     = k_q + IW'(1);
          state_d = S_ELIM;
        end else if (piv_found) begin
          p_d     = piv_row;
          state_d = S_SWAP;
        end else begin
          zero_d  = 1'b1;
          state_d = S_FINISH;
        end
      end

      S_SWAP: begin
        for (int c = 0; c < N; c++) begin
          a_d[k_q][c] = a_q[p_q][c];
          a_d[p_q][c] = a_q[k_q][c];
        end
        sign_d  = ~sign_q;
        i_d     = k_q + IW'(1);
        j_d     = k_q + IW'(1);
        state_d = S_ELIM;
      end

      S_ELIM: begin
        if (int'(j_q) == N - 1) begin
          if (int'(i_q) == N - 1) begin
            prev_d = a_q[k_q][k_q];
            if (int'(k_q) == N - 2) begin
              state_d = S_FINISH;
            end else begin
              k_d     = k_q + IW'(1);
              state_d = S_PIVOT;
            end
          end else begin
            i_d = i_q + IW'(1);
            j_d = k_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      S_FINISH: begin
        if (zero_q)      det_d = '0;
        else if (sign_q) det_d = -a_q[N-1][N-1];
        else             det_d = a_q[N-1][N-1];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      // NOTE: the working matrix is cleared on reset as well, so an aborted run leaves no stale operands behind.
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
        end
      end
      prev_q <= DET_W'(1);
      det_q  <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      k_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      p_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop take its _d value at the same edge.
      state_q <= state_d;
      a_q     <= a_d;
      prev_q  <= prev_d;
      det_q   <= det_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      p_q     <= p_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign det  = det_q;

endmodule

// File: tb/tb_determinante_nxn_seq.sv
// Scoreboard bench for determinante_nxn_seq: four instances (N=2..5) checked against
// a Leibniz-sum determinant and a minor-based pivot/latency model.
module tb_determinante_nxn_seq;

  localparam int W  = 8;
  localparam int DW = 48;
  localparam int NI = 4;   // instance u handles N = u + 2

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic                 start_s [NI];
  logic [5*5*W-1:0]     mat_s   [NI];
  logic                 busy_w  [NI];
  logic                 done_w  [NI];
  logic signed [DW-1:0] det_w   [NI];

  always #5 clk = ~clk;

  determinante_nxn_seq #(.N(2), .W(W), .DET_W(DW)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .matriz(mat_s[0][2*2*W-1:0]),
    .busy(busy_w[0]), .done(done_w[0]), .det(det_w[0]));
  determinante_nxn_seq #(.N(3), .W(W), .DET_W(DW)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .matriz(mat_s[1][3*3*W-1:0]),
    .busy(busy_w[1]), .done(done_w[1]), .det(det_w[1]));
  determinante_nxn_seq #(.N(4), .W(W), .DET_W(DW)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .matriz(mat_s[2][4*4*W-1:0]),
    .busy(busy_w[2]), .done(done_w[2]), .det(det_w[2]));
  determinante_nxn_seq #(.N(5), .W(W), .DET_W(DW)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start_s[3]), .matriz(mat_s[3][5*5*W-1:0]),
    .busy(busy_w[3]), .done(done_w[3]), .det(det_w[3]));

  typedef struct {
    longint det;
    int     lat;
  } exp_t;

  exp_t sb_q [NI][$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Determinant as the signed sum over all permutations.
  function automatic longint det_leib(input int n, input int m[8][8]);
    int     p [8];
    longint acc, prod;
    int     inv, a, b, tmp, lo, hi;
    bit     more;
    acc  = 0;
    more = 1'b1;
    for (int i = 0; i < 8; i++) p[i] = i;
    while (more) begin
      prod = 1;
      inv  = 0;
      for (int i = 0; i < n; i++) prod = prod * longint'(m[i][p[i]]);
      for (int i = 0; i < n; i++)
        for (int j = i + 1; j < n; j++)
          if (p[i] > p[j]) inv++;
      acc = (inv % 2 != 0) ? acc - prod : acc + prod;
      a = -1;
      for (int i = n - 2; i >= 0; i--) if (a < 0 && p[i] < p[i+1]) a = i;
      if (a < 0) begin
        more = 1'b0;
      end else begin
        b = n - 1;
        while (p[b] <= p[a]) b--;
        tmp = p[a]; p[a] = p[b]; p[b] = tmp;
        lo = a + 1;
        hi = n - 1;
        while (lo < hi) begin
          tmp = p[lo]; p[lo] = p[hi]; p[hi] = tmp;
          lo++;
          hi--;
        end
      end
    end
    return acc;
  endfunction

  // Pivot at step k is zero exactly when the leading minor (fixed rows above k plus the
  // candidate row, columns 0..k) is zero; this predicts swaps, early exit and latency.
  task automatic model(input int n, input int m[8][8], output longint d, output int lat);
    int ord [8];
    int sub [8][8];
    int p, row;
    bit early;
    d     = det_leib(n, m);
    lat   = 1;
    early = 1'b0;
    for (int i = 0; i < 8; i++) ord[i] = i;
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) sub[i][j] = 0;
    for (int k = 0; k < n - 1; k++) begin
      if (!early) begin
        lat++;
        p = -1;
        for (int r = k; r < n; r++) begin
          if (p < 0) begin
            for (int a = 0; a <= k; a++) begin
              row = (a < k) ? ord[a] : ord[r];
              for (int b = 0; b <= k; b++) sub[a][b] = m[row][b];
            end
            if (det_leib(k + 1, sub) != 0) p = r;
          end
        end
        if (p < 0) begin
          early = 1'b1;
        end else begin
          if (p != k) begin
            lat++;
            row = ord[k]; ord[k] = ord[p]; ord[p] = row;
          end
          lat += (n - 1 - k) * (n - 1 - k);
        end
      end
    end
    lat++;
  endtask

  task automatic load_mat(input int u, input int m[8][8]);
    logic [5*5*W-1:0] v;
    int n;
    n = u + 2;
    v = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        v[(r*n+c)*W +: W] = m[r][c][W-1:0];
    mat_s[u] = v;
  endtask

  // Pushes the expectation, raises start and returns right after the accepting edge.
  task automatic run_tx(input int u, input int m[8][8]);
    exp_t e;
    bit   last, ok;
    model(u + 2, m, e.det, e.lat);
    sb_q[u].push_back(e);
    load_mat(u, m);
    start_s[u] = 1'b1;
    last = busy_w[u];
    ok   = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(posedge clk);
      #1;
      if (busy_w[u] && !last) ok = 1'b1;
      last = busy_w[u];
    end
    if (!ok) check($sformatf("accept_timeout_n%0d", u + 2), 0, 1);
  endtask

  task automatic drain(input int u);
    int t;
    t = 0;
    while (sb_q[u].size() != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    #2;
    check($sformatf("drain_n%0d", u + 2), sb_q[u].size(), 0);
  endtask

  task automatic clear_m(output int m[8][8]);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) m[r][c] = 0;
  endtask

  task automatic rand_mat(input int n, output int m[8][8]);
    int mode;
    clear_m(m);
    mode = int'($urandom_range(0, 3));
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        case (mode)
          0:       m[r][c] = int'($urandom_range(0, 255)) - 128;
          1:       m[r][c] = int'($urandom_range(0, 2)) - 1;
          2:       m[r][c] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
          default: m[r][c] = ($urandom_range(0, 1) == 1) ? 127 : -128;
        endcase
      end
    end
    if (mode == 2) m[0][0] = 0;
  endtask

  task automatic rand_run(input int u);
    int m [8][8];
    for (int t = 0; t < 2000; t++) begin
      rand_mat(u + 2, m);
      run_tx(u, m);
    end
    start_s[u] = 1'b0;
    drain(u);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: acceptance is the edge busy rises; every done pops one expectation.
  int   acc_cyc   [NI];
  logic busy_prev [NI];
  exp_t mon_e;

  always @(posedge clk) begin
    #1;
    for (int u = 0; u < NI; u++) begin
      if (!rst_n) busy_prev[u] = 1'b0;
      if (busy_w[u] && !busy_prev[u]) acc_cyc[u] = cyc;
      busy_prev[u] = busy_w[u];
      if (done_w[u]) begin
        check($sformatf("done_expected_n%0d", u + 2), longint'(sb_q[u].size() > 0), 1);
        check($sformatf("busy_low_at_done_n%0d", u + 2), longint'(busy_w[u]), 0);
        if (sb_q[u].size() > 0) begin
          mon_e = sb_q[u].pop_front();
          check($sformatf("det_n%0d", u + 2), longint'(det_w[u]), mon_e.det);
          check($sformatf("latency_n%0d", u + 2), longint'(cyc - acc_cyc[u] + 1), longint'(mon_e.lat));
        end
      end
    end
    if (u2.elim_en) check("exact_div_n2", longint'(u2.num_w % u2.div_w != 0), 0);
    if (u3.elim_en) check("exact_div_n3", longint'(u3.num_w % u3.div_w != 0), 0);
    if (u4.elim_en) check("exact_div_n4", longint'(u4.num_w % u4.div_w != 0), 0);
    if (u5.elim_en) check("exact_div_n5", longint'(u5.num_w % u5.div_w != 0), 0);
  end

  initial begin
    real need;
    for (int n = 2; n <= 5; n++) begin
      need = real'(n * (W - 1)) + $ceil(real'(n) * $ln(real'(n)) / $ln(2.0) / 2.0) + 1.0;
      if (real'(DW) < need) begin
        $display("FAIL det_w_bound: DET_W=%0d too small for N=%0d", DW, n);
        $fatal(1, "DET_W bound violated");
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m [8][8];
    for (int u = 0; u < NI; u++) begin
      start_s[u] = 1'b0;
      mat_s[u]   = '0;
    end
    #12;
    for (int u = 0; u < NI; u++) begin
      check($sformatf("reset_busy_n%0d", u + 2), longint'(busy_w[u]), 0);
      check($sformatf("reset_done_n%0d", u + 2), longint'(done_w[u]), 0);
      check($sformatf("reset_det_n%0d", u + 2), longint'(det_w[u]), 0);
    end
    #10 rst_n = 1'b1;
    @(negedge clk);

    // 5x5 identity: det 1, done 36 edges after the accepting edge counts as edge 1.
    clear_m(m);
    for (int i = 0; i < 5; i++) m[i][i] = 1;
    run_tx(3, m);
    start_s[3] = 1'b0;
    drain(3);

    // N=2 back-to-back: swap case, odd-quotient case, most-negative elements.
    clear_m(m); m[0][1] = 1;  m[1][0] = 1;
    run_tx(0, m);
    clear_m(m); m[0][0] = 2;  m[0][1] = 1;  m[1][0] = 1;  m[1][1] = 2;
    run_tx(0, m);
    clear_m(m); m[0][0] = -128; m[0][1] = 127; m[1][0] = 127; m[1][1] = -128;
    run_tx(0, m);
    start_s[0] = 1'b0;
    drain(0);

    // N=5: two identical rows (early exit), then diagonal of -128.
    clear_m(m);
    m[0][0] = 1; m[0][1] = 1; m[1][0] = 1; m[1][1] = 1;
    m[2][2] = 1; m[3][3] = 1; m[4][4] = 1;
    run_tx(3, m);
    clear_m(m);
    for (int i = 0; i < 5; i++) m[i][i] = -128;
    run_tx(3, m);
    start_s[3] = 1'b0;
    drain(3);

    // A start pulse while busy must not create a second transaction.
    rand_mat(4, m);
    run_tx(2, m);
    start_s[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rand_mat(4, m);
    load_mat(2, m);
    start_s[2] = 1'b1;
    @(posedge clk);
    #1;
    start_s[2] = 1'b0;
    drain(2);
    repeat (40) @(posedge clk);

    // Reset in the middle of elimination aborts without a done.
    clear_m(m);
    for (int i = 0; i < 5; i++) m[i][i] = 3;
    load_mat(3, m);
    start_s[3] = 1'b1;
    @(posedge clk);
    #1;
    start_s[3] = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_busy_n5", longint'(busy_w[3]), 0);
    check("midreset_done_n5", longint'(done_w[3]), 0);
    check("midreset_det_n5", longint'(det_w[3]), 0);
    #7 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("after_reset_busy_n5", longint'(busy_w[3]), 0);
    check("after_reset_det_n5", longint'(det_w[3]), 0);

    // Random back-to-back traffic on N=3,4,5 in parallel.
    fork
      rand_run(1);
      rand_run(2);
      rand_run(3);
    join
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
